// File: rtl/volcano_pkg.sv
// volcano_pkg
//   Shared definitions for the volcano-name ASCII link, used by both the
//   receiver and the transmitter.
//   Contents: FSM state encoding, dictionary size, name IDs, the space
//   terminator and a character compare helper.
//   Optional build macro: VOLCANO_RX_CASE_FOLD_EN. When it is defined,
//   letters compare without regard to case. Non-letters, including the
//   space, always compare exactly.
package volcano_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MATCH = 2'b01,
    HUNT  = 2'b10
  } rx_state_t;

  localparam int NUM_NAMES = 6;
  localparam int MAX_LEN   = 11;

  localparam logic [2:0] ID_TAJUMULCO  = 3'd0;
  localparam logic [2:0] ID_TACANA     = 3'd1;
  localparam logic [2:0] ID_ACATENANGO = 3'd2;
  localparam logic [2:0] ID_FUEGO      = 3'd3;
  localparam logic [2:0] ID_SANTA_MARIA = 3'd4;
  localparam logic [2:0] ID_AGUA       = 3'd5;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

`ifdef VOLCANO_RX_CASE_FOLD_EN
  // Map lower-case letters onto upper case by clearing bit 5. Any byte
  // outside the two letter ranges passes through untouched.
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A))
      return c & 8'hDF;
    else
      return c;
  endfunction
`endif

  // Compare a dictionary character with a received byte.
  function automatic logic chars_equal(input logic [7:0] a,
                                       input logic [7:0] b);
`ifdef VOLCANO_RX_CASE_FOLD_EN
    return fold_case(a) == fold_case(b);
`else
    return a == b;
`endif
  endfunction

  // Pick the lowest set bit of a candidate mask as a name ID. Only one
  // bit can be set when a name completes, because the names are distinct.
  // The priority order is kept as a safeguard.
  function automatic logic [2:0] lowest_id(input logic [NUM_NAMES-1:0] m);
    logic [2:0] id;
    id = '0;
    for (int i = NUM_NAMES - 1; i >= 0; i--)
      if (m[i]) id = 3'(i);
    return id;
  endfunction

endpackage

// File: rtl/volcano_name_rom.sv
// volcano_name_rom
//   Combinational dictionary lookup. For a given character position it
//   returns the character of every name at that position, plus every name
//   length, so that all six candidates can be checked in parallel.
//   Ports:
//     pos    in   4                 character position within the name
//     chars  out  8*NUM_NAMES       char(k,pos) at [8k+7:8k]; 0 past the end
//     lens   out  4*NUM_NAMES       len(k) at [4k+3:4k]
module volcano_name_rom
  import volcano_pkg::*;
(
  input  logic [3:0]             pos,
  output logic [8*NUM_NAMES-1:0] chars,
  output logic [4*NUM_NAMES-1:0] lens
);

  // The names are stored right-aligned. The first character of each name
  // therefore sits at the byte offset len-1, and the last character sits
  // at offset 0.
  localparam logic [8*MAX_LEN-1:0] NAME_TEXT [NUM_NAMES] = '{
    {16'h0, "Tajumulco"},
    {40'h0, "Tacana"},
    {8'h0,  "Acatenango"},
    {48'h0, "Fuego"},
    "Santa Maria",
    {56'h0, "Agua"}
  };

  localparam logic [3:0] NAME_LEN [NUM_NAMES] = '{
    4'd9, 4'd6, 4'd10, 4'd5, 4'd11, 4'd4
  };

  logic [3:0] rel;

  // Look up every name in parallel. rel converts the position, counted
  // from the left of the name, into a byte offset counted from the right.
  always_comb begin
    chars = '0;
    lens  = '0;
    rel   = '0;
    for (int k = 0; k < NUM_NAMES; k++) begin
      lens[4*k +: 4] = NAME_LEN[k];
      if (pos < NAME_LEN[k]) begin
        rel = NAME_LEN[k] - 4'd1 - pos;
        chars[8*k +: 8] = NAME_TEXT[k][{rel, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/volcano_name_rx.sv
// volcano_name_rx
//   Receive side of the volcano-name ASCII stream. The block consumes one
//   byte on each strobe and identifies which of the six fixed names arrived.
//   Each name is terminated by a space.
//   Optional build macro: VOLCANO_RX_CASE_FOLD_EN, which enables a
//   case-insensitive letter compare.
//   Ports:
//     clk          in   1      rising-edge clock
//     rst          in   1      asynchronous active-high reset
//     rx_data      in   8      received ASCII byte
//     rx_valid     in   1      rx_data is consumed this cycle
//     flush        in   1      synchronous abort back to IDLE; it wins over rx_valid
//     match_valid  out  1      one-cycle pulse after a name and its terminator
//     match_id     out  3      ID of the last matched name (held)
//     err          out  1      one-cycle pulse on the byte that kills all candidates
//     match_count  out  CNT_W  matches since reset, saturating
//     busy         out  1      high while in MATCH or HUNT
module volcano_name_rx
  import volcano_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             flush,
  output logic             match_valid,
  output logic [2:0]       match_id,
  output logic             err,
  output logic [CNT_W-1:0] match_count,
  output logic             busy
);

  rx_state_t              state, state_n;
  logic [3:0]             pos, pos_n;
  logic [NUM_NAMES-1:0]   cand, cand_n;
  logic                   match_valid_n, err_n;
  logic [2:0]             match_id_n;
  logic [CNT_W-1:0]       match_count_n;

  logic [8*NUM_NAMES-1:0] rom_chars;
  logic [4*NUM_NAMES-1:0] rom_lens;
  logic [NUM_NAMES-1:0]   hit, done, live_hit, live_done;

  volcano_name_rom u_rom (
    .pos   (pos),
    .chars (rom_chars),
    .lens  (rom_lens)
  );

  // Score the incoming byte against every name at the current position.
  // done marks a name whose characters are all received and which now
  // sees its terminating space. hit marks a name whose next character
  // matches the byte. The terminator always needs an exact space, even
  // when case folding is enabled.
  always_comb begin
    hit  = '0;
    done = '0;
    for (int k = 0; k < NUM_NAMES; k++) begin
      if (pos == rom_lens[4*k +: 4])
        done[k] = (rx_data == ASCII_SPACE);
      else if (pos < rom_lens[4*k +: 4])
        hit[k] = chars_equal(rom_chars[8*k +: 8], rx_data);
    end
  end

  assign live_hit  = hit & cand;
  assign live_done = done & cand;

  // Next-state and output logic. The pulse outputs default low, so they
  // can only be high for the single cycle after the deciding byte. In
  // IDLE the candidate mask is always all ones, so the first byte is
  // checked against the whole dictionary.
  always_comb begin
    state_n       = state;
    pos_n         = pos;
    cand_n        = cand;
    match_valid_n = 1'b0;
    err_n         = 1'b0;
    match_id_n    = match_id;
    match_count_n = match_count;

    if (flush) begin
      state_n = IDLE;
      pos_n   = '0;
      cand_n  = '1;
    end else if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (rx_data != ASCII_SPACE) begin
            if (live_hit != '0) begin
              state_n = MATCH;
              pos_n   = 4'd1;
              cand_n  = live_hit;
            end else begin
              err_n   = 1'b1;
              state_n = HUNT;
            end
          end
        end
        MATCH: begin
          if (live_done != '0) begin
            match_valid_n = 1'b1;
            match_id_n    = lowest_id(live_done);
            if (match_count != '1)
              match_count_n = match_count + 1'b1;
            state_n = IDLE;
            pos_n   = '0;
            cand_n  = '1;
          end else if (live_hit != '0) begin
            pos_n  = pos + 4'd1;
            cand_n = live_hit;
          end else begin
            err_n   = 1'b1;
            state_n = HUNT;
          end
        end
        HUNT: begin
          if (rx_data == ASCII_SPACE) begin
            state_n = IDLE;
            pos_n   = '0;
            cand_n  = '1;
          end
        end
        default: begin
          state_n = IDLE;
          pos_n   = '0;
          cand_n  = '1;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pos         <= '0;
      cand        <= '1;
      match_valid <= 1'b0;
      match_id    <= '0;
      err         <= 1'b0;
      match_count <= '0;
    end else begin
      state       <= state_n;
      pos         <= pos_n;
      cand        <= cand_n;
      match_valid <= match_valid_n;
      match_id    <= match_id_n;
      err         <= err_n;
      match_count <= match_count_n;
    end
  end

  // busy is decoded straight from the state register, so it clears as
  // soon as reset asserts.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_volcano_name_rx.sv
// tb_volcano_name_rx
//   Self-checking bench for volcano_name_rx. A string-level reference
//   model collects the bytes of the current word. It compares that word
//   against each dictionary name, followed by a space, as a prefix, and
//   predicts the outputs after every clock.
//   Build macro VOLCANO_RX_CASE_FOLD_EN switches the model to a
//   case-insensitive letter compare, matching the DUT build.
module tb_volcano_name_rx;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       flush;
  logic       match_valid;
  logic [2:0] match_id;
  logic       err;
  logic [7:0] match_count;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  volcano_name_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .flush       (flush),
    .match_valid (match_valid),
    .match_id    (match_id),
    .err         (err),
    .match_count (match_count),
    .busy        (busy)
  );

  // Free-running clock with a 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: mode 0 = idle, 1 = inside a word, 2 = hunting.
  string      names [6] = '{"Tajumulco", "Tacana", "Acatenango",
                            "Fuego", "Santa Maria", "Agua"};
  int         mode;
  logic [7:0] word_q [$];
  logic       exp_mv;
  logic       exp_err;
  int         exp_id;
  int         exp_cnt;

  // Fold a letter onto upper case when the case-fold build is selected.
  function automatic logic [7:0] modelFold(input logic [7:0] c);
`ifdef VOLCANO_RX_CASE_FOLD_EN
    if (c >= "a" && c <= "z") return c - 8'd32;
`endif
    return c;
  endfunction

  // True when the word collected so far is a prefix of names[k] followed
  // by a space.
  function automatic bit isPrefix(input int k);
    logic [7:0] t;
    int n;
    n = names[k].len();
    if (word_q.size() > n + 1) return 0;
    for (int i = 0; i < word_q.size(); i++) begin
      t = (i < n) ? 8'(names[k].getc(i)) : 8'h20;
      if (i < n) begin
        if (modelFold(word_q[i]) != modelFold(t)) return 0;
      end else if (word_q[i] != t) begin
        return 0;
      end
    end
    return 1;
  endfunction

  // Score the current word. It either completes a name, stays a live
  // prefix of some name, or is rejected.
  task automatic modelEvaluate();
    int found;
    bit alive;
    found = -1;
    alive = 0;
    for (int k = 0; k < 6; k++) begin
      if (isPrefix(k)) begin
        if (word_q.size() == names[k].len() + 1) begin
          if (found < 0) found = k;
        end else begin
          alive = 1;
        end
      end
    end
    if (found >= 0) begin
      exp_mv = 1;
      exp_id = found;
      if (exp_cnt < 255) exp_cnt++;
      mode = 0;
      word_q.delete();
    end else if (alive) begin
      mode = 1;
    end else begin
      exp_err = 1;
      mode = 2;
      word_q.delete();
    end
  endtask

  task automatic modelStep(input logic [7:0] b, input logic v, input logic f);
    exp_mv  = 0;
    exp_err = 0;
    if (f) begin
      mode = 0;
      word_q.delete();
    end else if (v) begin
      case (mode)
        0: if (b != 8'h20) begin
             word_q.push_back(b);
             modelEvaluate();
           end
        1: begin
             word_q.push_back(b);
             modelEvaluate();
           end
        default: if (b == 8'h20) mode = 0;
      endcase
    end
  endtask

  task automatic modelReset();
    mode    = 0;
    word_q.delete();
    exp_mv  = 0;
    exp_err = 0;
    exp_id  = 0;
    exp_cnt = 0;
  endtask

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("match_valid", 32'(match_valid), 32'(exp_mv));
    checkOutput("err",         32'(err),         32'(exp_err));
    checkOutput("match_id",    32'(match_id),    32'(exp_id));
    checkOutput("match_count", 32'(match_count), 32'(exp_cnt));
    checkOutput("busy",        32'(busy),        32'(mode != 0));
  endtask

  // Drive one cycle of inputs on the falling edge, let the model take the
  // same step at the rising edge, and then compare just after that edge.
  task automatic applyStimulus(input logic [7:0] b, input logic v,
                               input logic f);
    @(negedge clk);
    rx_data  = b;
    rx_valid = v;
    flush    = f;
    @(posedge clk);
    modelStep(b, v, f);
    #1;
    checkAll();
  endtask

  // Send a string back-to-back. With gapPct above zero, idle cycles that
  // carry junk data are inserted at random between the bytes.
  task automatic sendString(input string s, input int gapPct);
    for (int i = 0; i < s.len(); i++) begin
      if (gapPct > 0 && $urandom_range(99) < gapPct)
        applyStimulus(8'($urandom), 1'b0, 1'b0);
      applyStimulus(8'(s.getc(i)), 1'b1, 1'b0);
    end
  endtask

  initial begin
    string w;
    logic [7:0] c;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    flush    = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    rst = 1'b0;

    // Directed sequences from the test plan.
    sendString("Fuego ", 0);
    sendString("Tajumulco Tacana Acatenango Fuego Santa Maria Agua ", 0);
    sendString("Tax ", 0);
    sendString("Agua ", 0);
    sendString("Fuegox", 0);
    sendString(" ", 0);
    sendString("Agu", 0);
    applyStimulus("a", 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    sendString("Agua ", 0);
    sendString("SANTA MARIA ", 0);
    sendString("fUEGO ", 0);
    sendString("Santa Xaria Agua ", 0);
    sendString("Agua  Fuego  ", 0);

    // Randomized words with case flips, corrupted characters, idle gaps
    // and flushes.
    for (int n = 0; n < 150; n++) begin
      w = names[$urandom_range(5)];
      for (int i = 0; i < w.len(); i++) begin
        c = 8'(w.getc(i));
        if ($urandom_range(7) == 0 && ((c >= "a" && c <= "z") || (c >= "A" && c <= "Z")))
          c = c ^ 8'h20;
        if ($urandom_range(19) == 0)
          c = 8'($urandom_range(8'h21, 8'h7E));
        if ($urandom_range(29) == 0)
          applyStimulus(c, 1'($urandom_range(1)), 1'b1);
        if ($urandom_range(4) == 0)
          applyStimulus(8'($urandom), 1'b0, 1'b0);
        applyStimulus(c, 1'b1, 1'b0);
      end
      applyStimulus(8'h20, 1'b1, 1'b0);
      if ($urandom_range(3) == 0) applyStimulus(8'h20, 1'b1, 1'b0);
    end

    // Counter saturation.
    for (int n = 0; n < 300; n++) sendString("Agua ", 0);

    // Asynchronous reset in the middle of a word: the outputs must clear
    // before any further clock edge.
    sendString("Fue", 0);
    #2;
    rst      = 1'b1;
    rx_valid = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rst = 1'b0;
    sendString("Agua ", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/volcano_name_rx.md
Name: volcano_name_rx

Overview:
- Receive side of the volcano-name ASCII stream. Consumes one byte per strobe and identifies which of the six fixed names arrived.
- Names: Tajumulco, Tacana, Acatenango, Fuego, Santa Maria, Agua. Every name is terminated by 0x20 (space).
- Sits behind the input switches / bidirectional input path. Reports the matched name ID, a match count and framing errors to the top-level output logic.

Parameters:
- NUM_NAMES, 6, number of names in the dictionary. Fixed by the ROM contents.
- MAX_LEN, 11, longest name in characters, not counting the terminator ("Santa Maria").
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received ASCII byte
- rx_valid  in  1  rx_data is consumed on any clock where this is high; there is no backpressure
- flush  in  1  synchronous abort; returns the block to IDLE
- match_valid  out  1  one-cycle pulse when a full name plus its terminator has been received
- match_id  out  3  ID of the last match: 0 Tajumulco, 1 Tacana, 2 Acatenango, 3 Fuego, 4 Santa Maria, 5 Agua; holds its value between matches
- err  out  1  one-cycle pulse on the first byte that eliminates all candidates
- match_count  out  CNT_W  total matches since reset, saturating at 255
- busy  out  1  high while in MATCH or HUNT

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, pos=0, cand=6'b111111, match_valid=0, match_id=0, err=0, match_count=0, busy=0.
- Internal state:
  - pos[3:0]: character position within the current name.
  - cand[5:0]: candidate mask, one bit per name.
  - ROM lookup char(k,pos) and len(k). Lengths are 9, 6, 10, 5, 11, 4.
- IDLE:
  - A valid space is ignored (inter-word padding).
  - A valid non-space byte computes cand' = bits k where char(k,0)==byte.
  - cand' nonzero: go to MATCH, pos=1.
  - cand' zero: pulse err, go to HUNT.
- MATCH, on each valid byte b:
  - For each surviving k:
    - pos==len(k) and b==0x20: k completes.
    - pos<len(k) and char(k,pos)==b: k survives.
    - Otherwise k is dropped.
  - Any k completes: match_id<=k, match_valid pulses, match_count increments (saturating), go to IDLE, pos=0, cand=all ones.
  - Else if some k survives: pos increments, stay in MATCH.
  - Else: pulse err, go to HUNT.
  - A space inside a name (Santa Maria, pos 5) is an ordinary character for candidate 4.
  - Completion is unique, because the dictionary names are distinct.
  - If more than one k ever completes, the lowest k wins (defensive only).
- HUNT:
  - Discard bytes until a valid space, then go to IDLE.
  - No err pulse while in HUNT; only the first offending byte pulses err.
  - Known behaviour: an error inside "Santa Maria" resyncs on its interior space.
- Latency: match_valid and err are registered and assert on the clock edge that consumes the deciding byte, visible the following cycle. Both are low in all other cycles.
- rx_valid low: state holds and no pulses are generated.
- Overlong input: pos can never exceed MAX_LEN. A byte at pos==len(k) that is not a space drops k, so the block errors out.
- flush high: go to IDLE, pos=0, cand=all ones, no pulses. flush wins over a simultaneous rx_valid, and that byte is dropped. match_id and match_count are kept.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: VOLCANO_RX_CASE_FOLD_EN.
- Defined: letters 0x41-0x5A and 0x61-0x7A compare case-insensitively (bit 5 ignored, letters only); "fUEGO " matches ID 3. Non-letters, including 0x20, still compare exactly.
- Undefined: exact byte compare; "fuego " produces err on the first byte.

Decomposition:
- Shared package volcano_pkg holds:
  - State enum with IDLE=2'b00, MATCH=2'b01, HUNT=2'b10.
  - NUM_NAMES and MAX_LEN.
  - Name ID localparams ID_TAJUMULCO through ID_AGUA.
  - ASCII_SPACE=8'h20.
- Package contents are reused by the transmitter.
- One sub-module, volcano_name_rom: combinational char(k,pos) and len(k) lookup for all six names in parallel.

Test Plan:
- Reset, then send "Fuego " (46 75 65 67 6F 20) on consecutive cycles -> match_valid one cycle after the 0x20 byte, match_id=3, match_count=1, err never high.
- Send the full transmitter stream "Tajumulco Tacana Acatenango Fuego Santa Maria Agua " -> six pulses with IDs 0,1,2,3,4,5 in order, match_count=6.
- Send "Tax " -> err pulse on 'x' (0x78) only, no match, then IDLE after 0x20; next "Agua " -> match_id=5.
- Send "Fuegox" then " " -> err on 'x'. Send "Agu" then assert flush with a simultaneous rx_valid byte 'a' -> no pulse, busy=0 next cycle, following "Agua " still matches.
- Send 300 "Agua " words -> match_count saturates at 255 with no wrap. Assert rst mid-word -> all outputs clear immediately, without waiting for a clock edge.
- With VOLCANO_RX_CASE_FOLD_EN defined, send "SANTA MARIA " -> match_id=4. Without the macro, the same input gives err on 'A' at pos 1.
